ad7946_scheduler: RTL and testbench
===================================

// Module: ad7946_scheduler
// PURPOSE
// - Shares one AD7946 dual-channel 14-bit ADC between two requesters. Drives the ADC pins directly.
// - Round-robin arbitration. Each grant runs one CS-framed serial read of the requested channel.
// - Returns the 14-bit result tagged with its channel and the requester that asked for it.
// - Sits between the ADC pins and the processing logic. Replaces the free-running ch0/ch1 controller
//   wherever on-demand sampling is needed.
// PARAMETERS
// - SCLK_DIV    4     clk cycles per sclk half-period (>=1); sclk period = 2*SCLK_DIV clk
// - QUIET_CLKS  100   minimum clk cycles cs_n stays high between frames (>=1), covers conversion
// - IDLE_PD     1000  idle clk cycles before auto power-down (only with AD7946_PDEN_AUTO_EN)
// - WAKE_CLKS   500   clk cycles from pden release to first frame (only with AD7946_PDEN_AUTO_EN)
// PORTS
// - clk         in   1   system clock; the only clock
// - reset       in   1   asynchronous, active-high reset
// - req0        in   1   requester 0 wants a sample; held until gnt0
// - req0_ch     in   1   channel for requester 0 (0=ch0, 1=ch1); must be stable while req0=1
// - gnt0        out  1   1-cycle pulse: req0 accepted, frame started
// - req1        in   1   requester 1 request
// - req1_ch     in   1   channel for requester 1
// - gnt1        out  1   1-cycle pulse: req1 accepted
// - dout_valid  out  1   1-cycle pulse: dout/dout_ch/dout_tag valid
// - dout        out  14  conversion result, MSB first off the wire
// - dout_ch     out  1   channel of dout
// - dout_tag    out  1   requester of dout (0/1)
// - busy        out  1   high from the grant cycle to the end of QUIET
// - pden        out  1   ADC power-down pin
// - chsel       out  1   ADC channel-select pin
// - cs_n        out  1   ADC chip select, active low
// - sclk        out  1   ADC serial clock, idles high
// - sdi         in   1   ADC serial data out (SDO)
// BEHAVIOUR
// - Reset values: cs_n=1, sclk=1, pden=0, chsel=0, gnt0=gnt1=0, dout_valid=0, dout=0,
//   dout_ch=0, dout_tag=0, busy=0.
// - Reset is asynchronous. Asserting it mid-frame forces cs_n=1 and sclk=1 immediately.
//   The partial frame is discarded: no dout_valid.
// - FSM states: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE, plus PD and WAKE (feature only).
// - IDLE: on any req, grant one requester.
//   - If both request, grant the one not granted last. The last-grant pointer resets to 1, so req0 wins first.
//   - Cycle T (grant cycle): gntN=1, chsel<=reqN_ch, busy=1, go to SETUP.
//   - Requests are not latched. A req dropped before its gnt is never served.
//   - A request arriving during a frame waits for IDLE.
// - SETUP: SCLK_DIV cycles with chsel stable and cs_n=1. cs_n falls at T+SCLK_DIV.
// - SHIFT: 16 sclk periods with cs_n low.
//   - sclk falls SCLK_DIV cycles after cs_n falls, rises SCLK_DIV later, and so on.
//   - sdi is sampled on each sclk rising edge.
//   - Rising edges 1-2 are leading zeros and are ignored. Edges 3..16 give dout[13:0], MSB first.
// - End of SHIFT, cycle T+33*SCLK_DIV (T+132 at default SCLK_DIV=4):
//   - cs_n returns to 1.
//   - dout_valid=1 for one cycle, with dout, dout_ch=chsel and dout_tag=requester.
// - dout, dout_ch and dout_tag hold their values until the next dout_valid.
// - QUIET: cs_n=1, sclk=1 for QUIET_CLKS cycles. Then busy drops and the FSM returns to IDLE.
//   - A pending req is granted in the IDLE cycle right after QUIET.
// - gnt0 and gnt1 are never high in the same cycle. At most one frame is in flight.
// - Counters: clk divider width from SCLK_DIV; bit counter 0..15. Both clear in IDLE.
// CONFIGURATION
// - AD7946_PDEN_AUTO_EN defined:
//   - IDLE with no req for IDLE_PD consecutive cycles -> PD, pden=1.
//   - Any req in PD -> WAKE: pden=0, wait WAKE_CLKS cycles, return to IDLE, arbitrate normally.
//   - A req seen during WAKE is not granted until WAKE ends.
//   - Reset leaves pden=0 and restarts the idle count.
// - AD7946_PDEN_AUTO_EN undefined:
//   - pden is held at 0. PD and WAKE states are absent. IDLE_PD and WAKE_CLKS are ignored.
// TESTING
// - Model sdo=0x2A5C, req0=1, req0_ch=0:
//   gnt0 pulse at T; cs_n low T+4..T+131; 16 sclk falls;
//   dout_valid at T+132 with dout=0x2A5C, dout_ch=0, dout_tag=0.
// - req0 (ch0) and req1 (ch1) both held high:
//   grants alternate gnt0, gnt1, gnt0...; chsel alternates 0/1;
//   cs_n high >=100 cycles between frames.
// - reset pulse during SHIFT:
//   cs_n=1 and sclk=1 in the same cycle; no dout_valid;
//   after release, req1 ch1 is served with dout_tag=1.
// - req1 raised then dropped while busy, before IDLE: no gnt1, no extra cs_n frame.
// - Macro on: 1000 idle cycles -> pden=1; req0 -> pden=0, gnt0 500 cycles later.
//   Macro off: pden stays 0 throughout.

Source files
------------

// File: rtl/ad7946_scheduler.sv
// ad7946_scheduler: shares one AD7946 dual-channel 14-bit ADC between two
// requesters with round-robin arbitration. Each grant runs one CS-framed
// 16-clock serial read of the requested channel and returns the result
// tagged with its channel and requester.
// Optional feature macro: AD7946_PDEN_AUTO_EN (auto power-down after an
// idle period, timed wake-up on the next request).
module ad7946_scheduler #(
    parameter int SCLK_DIV   = 4,
    parameter int QUIET_CLKS = 100,
    parameter int IDLE_PD    = 1000,
    parameter int WAKE_CLKS  = 500
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_i,
    input  logic        req0_ch_i,
    output logic        gnt0_o,
    input  logic        req1_i,
    input  logic        req1_ch_i,
    output logic        gnt1_o,
    output logic        dout_valid_o,
    output logic [13:0] dout_o,
    output logic        dout_ch_o,
    output logic        dout_tag_o,
    output logic        busy_o,
    output logic        pden_o,
    output logic        chsel_o,
    output logic        cs_n_o,
    output logic        sclk_o,
    input  logic        sdi_i
);
    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int MAX_A   = (QUIET_CLKS > IDLE_PD) ? QUIET_CLKS : IDLE_PD;
    localparam int CNT_MAX = (MAX_A > WAKE_CLKS) ? MAX_A : WAKE_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Divider terminal values: SHIFT toggles sclk every SCLK_DIV cycles; SETUP
    // lasts SCLK_DIV-1 cycles because the grant cycle itself counts toward it.
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(SCLK_DIV - 2);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CLKS - 1);

`ifdef AD7946_PDEN_AUTO_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_PD - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CLKS - 1);
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET, ST_PD, ST_WAKE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET} state_t;
`endif

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [13:0]       shift_q, shift_d;
    logic [13:0]       dout_q, dout_d;
    logic              dout_ch_q, dout_ch_d;
    logic              dout_tag_q, dout_tag_d;
    logic              dout_valid_q, dout_valid_d;
    logic              chsel_q, chsel_d;
    logic              tag_q, tag_d;
    logic              last_q, last_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              pden_q, pden_d;
    logic              gnt0_c, gnt1_c;
    logic              pick1;

    // Next-state, arbitration and frame-sequencing logic.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_tag_d   = dout_tag_q;
        dout_valid_d = 1'b0;
        chsel_d      = chsel_q;
        tag_d        = tag_q;
        last_d       = last_q;
        sclk_d       = sclk_q;
        pden_d       = pden_q;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        // Requester 1 wins when alone, or when both ask and 0 was served last.
        pick1        = req1_i && (!req0_i || !last_q);

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (req0_i || req1_i) begin
                    gnt0_c  = !pick1;
                    gnt1_c  = pick1;
                    chsel_d = pick1 ? req1_ch_i : req0_ch_i;
                    tag_d   = pick1;
                    last_d  = pick1;
                    cnt_d   = '0;
                    state_d = (SCLK_DIV == 1) ? ST_SHIFT : ST_SETUP;
`ifdef AD7946_PDEN_AUTO_EN
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    pden_d  = 1'b1;
                    state_d = ST_PD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`else
                end else begin
                    cnt_d = '0;
`endif
                end
            end
            ST_SETUP: begin
                if (div_q == SETUP_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    // sdi is captured on the clk edge that raises sclk.
                    if (!sclk_q) begin
                        shift_d = {shift_q[12:0], sdi_i};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            dout_d       = {shift_q[12:0], sdi_i};
                            dout_ch_d    = chsel_q;
                            dout_tag_d   = tag_q;
                            dout_valid_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = ST_QUIET;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef AD7946_PDEN_AUTO_EN
            ST_PD: begin
                if (req0_i || req1_i) begin
                    pden_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // cs_n is low exactly while the frame is shifting.
        cs_n_d = (state_d != ST_SHIFT);
    end

    // State and pin registers; reset forces the ADC pins idle at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_ch_q    <= 1'b0;
            dout_tag_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            chsel_q      <= 1'b0;
            tag_q        <= 1'b0;
            last_q       <= 1'b1;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            pden_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_tag_q   <= dout_tag_d;
            dout_valid_q <= dout_valid_d;
            chsel_q      <= chsel_d;
            tag_q        <= tag_d;
            last_q       <= last_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            pden_q       <= pden_d;
        end
    end

    // Grants are combinational in the IDLE cycle; masked while reset is held.
    assign gnt0_o       = gnt0_c && !reset_i;
    assign gnt1_o       = gnt1_c && !reset_i;
    assign busy_o       = gnt0_o || gnt1_o || (state_q == ST_SETUP) ||
                          (state_q == ST_SHIFT) || (state_q == ST_QUIET);
    assign dout_valid_o = dout_valid_q;
    assign dout_o       = dout_q;
    assign dout_ch_o    = dout_ch_q;
    assign dout_tag_o   = dout_tag_q;
    assign chsel_o      = chsel_q;
    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;
`ifdef AD7946_PDEN_AUTO_EN
    assign pden_o       = pden_q;
`else
    assign pden_o       = 1'b0;
`endif

endmodule

// File: tb/tb_ad7946_scheduler.sv
// tb_ad7946_scheduler: randomized requests against a transaction-level model
// (round-robin pointer, expected frame timing) plus an ADC model that serves a
// random 16-bit word per frame on the serial pins.
`timescale 1ns/1ps
module tb_ad7946_scheduler;
    localparam int SCLK_DIV   = 4;
    localparam int QUIET_CLKS = 100;
    localparam int IDLE_PD    = 1000;
    localparam int WAKE_CLKS  = 500;
    localparam int FRAME      = 33 * SCLK_DIV;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req0_i = 1'b0, req0_ch_i = 1'b0, req1_i = 1'b0, req1_ch_i = 1'b0;
    logic        sdi_i = 1'b0;
    logic        gnt0_o, gnt1_o, dout_valid_o, dout_ch_o, dout_tag_o, busy_o;
    logic        pden_o, chsel_o, cs_n_o, sclk_o;
    logic [13:0] dout_o;

    ad7946_scheduler #(
        .SCLK_DIV(SCLK_DIV), .QUIET_CLKS(QUIET_CLKS), .IDLE_PD(IDLE_PD), .WAKE_CLKS(WAKE_CLKS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0_i(req0_i), .req0_ch_i(req0_ch_i), .gnt0_o(gnt0_o),
        .req1_i(req1_i), .req1_ch_i(req1_ch_i), .gnt1_o(gnt1_o),
        .dout_valid_o(dout_valid_o), .dout_o(dout_o), .dout_ch_o(dout_ch_o),
        .dout_tag_o(dout_tag_o), .busy_o(busy_o), .pden_o(pden_o), .chsel_o(chsel_o),
        .cs_n_o(cs_n_o), .sclk_o(sclk_o), .sdi_i(sdi_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ADC model: new random word at each cs_n fall; MSB out first, each
    // following bit presented after an sclk fall. Top two bits are random so
    // the bench sees whether edges 1-2 are really discarded.
    logic [15:0] adc_word = '0;
    int          adc_falls = 0;
    logic        cs_n_prev = 1'b1, sclk_prev = 1'b1;
    logic [13:0] adc_q[$];
    always @(negedge clk_i) begin
        if (cs_n_prev && !cs_n_o) begin
            adc_word  = 16'($urandom);
            adc_q.push_back(adc_word[13:0]);
            adc_falls = 0;
            sdi_i     = adc_word[15];
        end else if (!cs_n_o && sclk_prev && !sclk_o) begin
            if (adc_falls < 16) sdi_i = adc_word[15 - adc_falls];
            adc_falls++;
        end
        cs_n_prev = cs_n_o;
        sclk_prev = sclk_o;
    end

    // Request model and round-robin reference.
    bit want[2];
    bit want_ch[2];
    bit last_tag = 1'b1;

    task automatic apply_reqs();
        req0_i    = want[0];
        req0_ch_i = want_ch[0];
        req1_i    = want[1];
        req1_ch_i = want_ch[1];
    endtask

    // Wait for a grant, then follow the whole frame and check it.
    task automatic serve(input int max_wait, output int t_gnt);
        bit          exp_tag, exp_ch;
        int          k, t_cs, t_cs_last, t_valid;
        logic [13:0] exp_d;
        exp_tag   = (want[0] && want[1]) ? !last_tag : want[1];
        exp_ch    = want_ch[exp_tag];
        t_cs      = -1;
        t_cs_last = -1;
        t_valid   = -1;
        exp_d     = '0;
        #1;
        k = 0;
        while (!(gnt0_o || gnt1_o) && k < max_wait) begin
            @(negedge clk_i);
            k++;
        end
        t_gnt = cyc;
        if (!(gnt0_o || gnt1_o)) begin
            check_value("gnt_timeout", 0, 1);
            return;
        end
        check_value("gnt_tag", gnt1_o, exp_tag);
        check_value("gnt_excl", gnt0_o & gnt1_o, 0);
        check_value("busy_at_gnt", busy_o, 1);
        last_tag = exp_tag;
        for (k = 1; k <= FRAME + 2; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                want[exp_tag] = 1'b0;
                apply_reqs();
                check_value("chsel", chsel_o, exp_ch);
            end
            if (!cs_n_o) begin
                if (t_cs < 0) t_cs = k;
                t_cs_last = k;
            end
            if (gnt0_o || gnt1_o) check_value("gnt_in_frame", 1, 0);
            if (dout_valid_o) begin
                if (t_valid >= 0) check_value("valid_twice", k, t_valid);
                t_valid = k;
                if (adc_q.size() == 0) check_value("adc_frame_missing", 0, 1);
                else exp_d = adc_q.pop_front();
                check_value("dout", dout_o, exp_d);
                check_value("dout_ch", dout_ch_o, exp_ch);
                check_value("dout_tag", dout_tag_o, exp_tag);
                check_value("sclk_falls", adc_falls, 16);
                check_value("cs_n_at_valid", cs_n_o, 1);
                check_value("busy_at_valid", busy_o, 1);
                check_value("pden_in_frame", pden_o, 0);
            end
        end
        check_value("cs_fall_lat", t_cs, SCLK_DIV);
        check_value("cs_last_low", t_cs_last, FRAME - 1);
        check_value("valid_lat", t_valid, FRAME);
        check_value("dout_hold", dout_o, exp_d);
        $display("frame: tag=%0d ch=%0d dout=0x%0h gnt_cycle=%0d", exp_tag, exp_ch, exp_d, t_gnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, prev_t, k, cnt_a, cnt_b, p;
        prev_t = 0;

        // Reset values.
        repeat (3) @(negedge clk_i);
        check_value("rst_cs_n", cs_n_o, 1);
        check_value("rst_sclk", sclk_o, 1);
        check_value("rst_pden", pden_o, 0);
        check_value("rst_chsel", chsel_o, 0);
        check_value("rst_gnt", {gnt1_o, gnt0_o}, 0);
        check_value("rst_valid", dout_valid_o, 0);
        check_value("rst_dout", dout_o, 0);
        check_value("rst_dout_ch_tag", {dout_ch_o, dout_tag_o}, 0);
        check_value("rst_busy", busy_o, 0);
        reset_i = 1'b0;

        // Random request patterns; first pass has both asking (req0 wins).
        for (int it = 0; it < 12; it++) begin
            if (it == 0) begin
                want[0] = 1'b1; want_ch[0] = 1'b0;
                want[1] = 1'b1; want_ch[1] = 1'b1;
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (!want[r] && $urandom_range(0, 1) == 1) begin
                        want[r]    = 1'b1;
                        want_ch[r] = 1'($urandom_range(0, 1));
                    end
                end
                if (!want[0] && !want[1]) begin
                    p          = int'($urandom_range(0, 1));
                    want[p]    = 1'b1;
                    want_ch[p] = 1'($urandom_range(0, 1));
                end
            end
            apply_reqs();
            serve(FRAME + QUIET_CLKS + 20, t);
            if (it > 0) check_value("gnt_gap", t - prev_t, FRAME + QUIET_CLKS);
            prev_t = t;
        end
        while (want[0] || want[1]) begin
            apply_reqs();
            serve(FRAME + QUIET_CLKS + 20, t);
        end

        // req1 raised and dropped while busy: never served.
        want[1] = 1'b1; want_ch[1] = 1'($urandom_range(0, 1));
        apply_reqs();
        cnt_a = 0; cnt_b = 0;
        for (k = 0; k < 260; k++) begin
            @(negedge clk_i);
            if (k == 10) begin
                want[1] = 1'b0;
                apply_reqs();
            end
            if (gnt0_o || gnt1_o) cnt_a++;
            if (!cs_n_o) cnt_b++;
        end
        check_value("dropped_req_gnts", cnt_a, 0);
        check_value("dropped_req_frames", cnt_b, 0);

        // Reset in the middle of SHIFT.
        want[0] = 1'b1; want_ch[0] = 1'b0;
        apply_reqs();
        #1;
        k = 0;
        while (!gnt0_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        check_value("rst_test_gnt0", gnt0_o, 1);
        @(negedge clk_i);
        want[0] = 1'b0;
        apply_reqs();
        repeat (49) @(negedge clk_i);
        check_value("pre_rst_cs_n", cs_n_o, 0);
        check_value("pre_rst_sclk", sclk_o, 0);
        reset_i = 1'b1;
        #1;
        check_value("mid_rst_cs_n", cs_n_o, 1);
        check_value("mid_rst_sclk", sclk_o, 1);
        check_value("mid_rst_busy", busy_o, 0);
        cnt_a = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (dout_valid_o) cnt_a++;
        end
        reset_i = 1'b0;
        adc_q.delete();
        last_tag = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (dout_valid_o) cnt_a++;
        end
        check_value("rst_no_valid", cnt_a, 0);
        want[1] = 1'b1; want_ch[1] = 1'b1;
        apply_reqs();
        serve(40, t);

`ifdef AD7946_PDEN_AUTO_EN
        // Auto power-down after IDLE_PD idle cycles, then timed wake.
        k = 0;
        while (busy_o && k < 400) begin
            @(negedge clk_i);
            k++;
        end
        k = 0;
        while (!pden_o && k < 3 * IDLE_PD) begin
            @(negedge clk_i);
            k++;
        end
        check_value("pd_entry_delay", k, IDLE_PD);
        want[0] = 1'b1; want_ch[0] = 1'b1;
        apply_reqs();
        p = cyc;
        @(negedge clk_i);
        check_value("pden_release", pden_o, 0);
        serve(WAKE_CLKS + 50, t);
        check_value("wake_to_gnt", t - (p + 1), WAKE_CLKS);
`else
        // Without the feature pden never rises, however long the idle.
        cnt_a = 0;
        repeat (IDLE_PD + 200) begin
            @(negedge clk_i);
            if (pden_o) cnt_a++;
        end
        check_value("pden_stays_low", cnt_a, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
